bomb_arbiter: RTL and testbench
===============================

BOMB_ARBITER -- requirements
Module: bomb_arbiter

Interface
REQ-001 Parameter NUM_MODULES, 4, number of bomb puzzle modules sharing the event path.
REQ-002 Parameter MAX_STRIKES, 3, strike count that loses the game (range 1..3).
REQ-003 Port clock  input  1  65 MHz game clock; the only clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port begin_setup  input  1  one-cycle cue from the game FSM to start a new round.
REQ-006 Port enable  input  1  high while the game is being played; low pauses all arbitration.
REQ-007 Port timer_expired  input  1  level from the countdown timer; high means time is up.
REQ-008 Port req  input  NUM_MODULES  per-module event request; held until that module's grant.
REQ-009 Port event_code  input  2*NUM_MODULES  per-module code, slice [2i+1:2i]: 01 strike, 10 solved, 00/11 no-op.
REQ-010 Port grant  output  NUM_MODULES  one-hot grant, at most one bit high, high for exactly one cycle.
REQ-011 Port strikes  output  2  current strike count.
REQ-012 Port solved  output  NUM_MODULES  bit i set once module i is solved.
REQ-013 Port strike_pulse  output  1  one-cycle pulse per accepted strike, for the buzzer and LEDs.
REQ-014 Port game_won  output  1  level, high in state WON.
REQ-015 Port game_lost  output  1  level, high in state LOST.
REQ-016 Port state  output  3  encoding IDLE=000, SETUP=001, ARMED=100, WON=010, LOST=011.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States and transitions:
- IDLE goes to SETUP on begin_setup.
- SETUP goes to ARMED when enable=1.
- ARMED goes to LOST or WON per REQ-024 to REQ-026.
- WON and LOST hold until begin_setup.
REQ-019 begin_setup=1 in any state SHALL, at that edge, clear strikes, solved, grant and the priority pointer, and enter SETUP.
REQ-020 Grants SHALL be issued only in ARMED with enable=1, at most one per edge.
REQ-021 Arbitration rules:
- Round-robin; the highest priority is the module after the one last granted.
- The pointer resets to module 0 highest.
REQ-022 Eligible requester i: req[i]=1, solved[i]=0, and i was not granted at the previous edge (masks the requester's one-cycle drop latency).
REQ-023 At the edge that asserts grant[i], the arbiter SHALL apply event_code slice i:
- Strike: strikes increments, saturating at MAX_STRIKES, and strike_pulse=1 for that cycle.
- Solved: sets solved[i].
- No-op: changes nothing, but the grant is still issued.
REQ-024 When the strike count reaches MAX_STRIKES, the arbiter SHALL enter LOST at the following edge and issue no further grants.
REQ-025 When all solved bits are set, the arbiter SHALL enter WON at the following edge.
REQ-026 timer_expired=1 in ARMED with enable=1 SHALL enter LOST at that edge. timer_expired SHALL take priority over a simultaneous win or strike, and no grant is issued at that edge.
REQ-027 With enable=0 in ARMED, the arbiter SHALL hold state, counters and pointer, and issue no grants; pending requests remain pending.
REQ-028 In IDLE, SETUP, WON and LOST: grant=0, strike_pulse=0, and req and timer_expired are ignored.
REQ-029 Latency: req[i] high at edge k with no competitor gives grant[i]=1 and the updated strikes/solved visible in cycle k+1.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL set state=IDLE, grant=0, strikes=0, solved=0, strike_pulse=0, game_won=0, game_lost=0, and the pointer to module 0.
REQ-031 reset SHALL override begin_setup and all other inputs.
REQ-032 Reset mid-round SHALL discard all pending requests.

Verification
REQ-033 Reset, begin_setup, enable=1, then req=0001 with code 10 -> grant=0001 for exactly 1 cycle, solved=0001, state=100.
REQ-034 In ARMED, req=1111 all no-op, each requester held until its grant -> grants 0001, 0010, 0100, 1000 on consecutive cycles; no grant repeats.
REQ-035 Three strike events from module 2 -> three strike_pulses, strikes=3, state=LOST and game_lost=1 one edge after the third, grant=0 afterwards.
REQ-036 Final solve granted at the same edge timer_expired rises -> state=LOST, not WON.
REQ-037 enable=0 with req=0100 pending for 10 cycles -> no grant; enable=1 -> grant=0100 next cycle.
REQ-038 In LOST, pulse begin_setup -> strikes=0, solved=0000, state=SETUP, game_lost=0.

Source files
------------

// File: rtl/bomb_arbiter.sv
// Event arbiter for the bomb game: round-robin grants puzzle-module events,
// tracks strikes and solved modules, and runs the round FSM (IDLE/SETUP/ARMED/WON/LOST).
module bomb_arbiter #(
    parameter int NUM_MODULES = 4,
    parameter int MAX_STRIKES = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     begin_setup,
    input  logic                     enable,
    input  logic                     timer_expired,
    input  logic [NUM_MODULES-1:0]   req,
    input  logic [2*NUM_MODULES-1:0] event_code,
    output logic [NUM_MODULES-1:0]   grant,
    output logic [1:0]               strikes,
    output logic [NUM_MODULES-1:0]   solved,
    output logic                     strike_pulse,
    output logic                     game_won,
    output logic                     game_lost,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SETUP = 3'b001,
        ST_ARMED = 3'b100,
        ST_WON   = 3'b010,
        ST_LOST  = 3'b011
    } state_t;

    localparam int PTR_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
    localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MODULES - 1);

    state_t                 state_reg, state_next;
    logic [NUM_MODULES-1:0] grant_reg, grant_next;
    logic [1:0]             strikes_reg, strikes_next;
    logic [NUM_MODULES-1:0] solved_reg, solved_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic                   pulse_reg, pulse_next;
    logic                   won_reg, won_next;
    logic                   lost_reg, lost_next;

    logic [NUM_MODULES-1:0] eligible;
    logic [NUM_MODULES-1:0] is_strike;
    logic [NUM_MODULES-1:0] is_solve;
    logic                   pick_valid;
    logic [PTR_W-1:0]       pick_idx;
    logic [PTR_W-1:0]       cand;

    // A module granted last edge is masked: its req may still be high while it drops.
    generate
        for (genvar gi = 0; gi < NUM_MODULES; gi++) begin : g_decode
            assign eligible[gi]  = req[gi] & ~solved_reg[gi] & ~grant_reg[gi];
            assign is_strike[gi] = (event_code[2*gi+1:2*gi] == 2'b01);
            assign is_solve[gi]  = (event_code[2*gi+1:2*gi] == 2'b10);
        end
    endgenerate

    // Scan from the pointer upward, wrapping, and take the first eligible module.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 0; off < NUM_MODULES; off++) begin
            cand = PTR_W'((int'(ptr_reg) + off) % NUM_MODULES);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = '0;
        strikes_next = strikes_reg;
        solved_next  = solved_reg;
        ptr_next     = ptr_reg;
        pulse_next   = 1'b0;

        if (begin_setup) begin
            state_next   = ST_SETUP;
            strikes_next = '0;
            solved_next  = '0;
            ptr_next     = '0;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_SETUP: begin
                    if (enable) state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (enable) begin
                        // Timeout beats a pending win or strike; no grant on the losing edge.
                        if (timer_expired || (strikes_reg >= STRIKE_LIMIT)) begin
                            state_next = ST_LOST;
                        end else if (&solved_reg) begin
                            state_next = ST_WON;
                        end else if (pick_valid) begin
                            grant_next[pick_idx] = 1'b1;
                            ptr_next = (pick_idx == LAST_IDX) ? '0 : PTR_W'(int'(pick_idx) + 1);
                            if (is_strike[pick_idx]) begin
                                pulse_next = 1'b1;
                                if (strikes_reg < STRIKE_LIMIT) strikes_next = strikes_reg + 2'd1;
                            end else if (is_solve[pick_idx]) begin
                                solved_next[pick_idx] = 1'b1;
                            end
                        end
                    end
                end
                ST_WON, ST_LOST: ;
                default: state_next = ST_IDLE;
            endcase
        end

        won_next  = (state_next == ST_WON);
        lost_next = (state_next == ST_LOST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            strikes_reg <= '0;
            solved_reg  <= '0;
            ptr_reg     <= '0;
            pulse_reg   <= 1'b0;
            won_reg     <= 1'b0;
            lost_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            strikes_reg <= strikes_next;
            solved_reg  <= solved_next;
            ptr_reg     <= ptr_next;
            pulse_reg   <= pulse_next;
            won_reg     <= won_next;
            lost_reg    <= lost_next;
        end
    end

    assign grant        = grant_reg;
    assign strikes      = strikes_reg;
    assign solved       = solved_reg;
    assign strike_pulse = pulse_reg;
    assign game_won     = won_reg;
    assign game_lost    = lost_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_bomb_arbiter.sv
// Directed testbench for bomb_arbiter: hand-computed expectations for reset,
// round-robin order, solve/strike bookkeeping, pause, timeout, win and restart.
`timescale 1ns/1ps
module tb_bomb_arbiter;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_SETUP = 3'b001;
    localparam logic [2:0] S_ARMED = 3'b100;
    localparam logic [2:0] S_WON   = 3'b010;
    localparam logic [2:0] S_LOST  = 3'b011;

    logic       clock = 1'b0;
    logic       reset;
    logic       begin_setup;
    logic       enable;
    logic       timer_expired;
    logic [3:0] req;
    logic [7:0] event_code;
    logic [3:0] grant;
    logic [1:0] strikes;
    logic [3:0] solved;
    logic       strike_pulse;
    logic       game_won;
    logic       game_lost;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;
    logic [3:0] acc;

    bomb_arbiter #(.NUM_MODULES(4), .MAX_STRIKES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .begin_setup  (begin_setup),
        .enable       (enable),
        .timer_expired(timer_expired),
        .req          (req),
        .event_code   (event_code),
        .grant        (grant),
        .strikes      (strikes),
        .solved       (solved),
        .strike_pulse (strike_pulse),
        .game_won     (game_won),
        .game_lost    (game_lost),
        .state        (state)
    );

    always #8 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    initial begin
        reset = 1'b1; begin_setup = 1'b1; enable = 1'b0; timer_expired = 1'b0;
        req = '0; event_code = '0;
        step(); step();
        check("rst_state",   32'(state), 32'(S_IDLE));
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_strikes", 32'(strikes), 32'h0);
        check("rst_solved",  32'(solved), 32'h0);
        check("rst_pulse",   32'(strike_pulse), 32'h0);
        check("rst_won",     32'(game_won), 32'h0);
        check("rst_lost",    32'(game_lost), 32'h0);

        reset = 1'b0; begin_setup = 1'b0;
        step();
        check("idle_hold", 32'(state), 32'(S_IDLE));
        begin_setup = 1'b1; step(); begin_setup = 1'b0;
        check("setup_enter", 32'(state), 32'(S_SETUP));
        step();
        check("setup_wait", 32'(state), 32'(S_SETUP));
        enable = 1'b1; step();
        check("armed_enter", 32'(state), 32'(S_ARMED));

        // Four no-op requesters, each dropping its req once granted.
        req = 4'b1111; event_code = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_grant", 32'(grant), 32'(4'b0001 << k));
            req = req & ~grant;
        end
        step();
        check("rr_idle", 32'(grant), 32'h0);

        // Single solve from module 0.
        req = 4'b0001; event_code = 8'b0000_0010;
        step();
        check("solve0_grant",  32'(grant), 32'h1);
        check("solve0_solved", 32'(solved), 32'h1);
        check("solve0_state",  32'(state), 32'(S_ARMED));
        req = 4'b0000;
        step();
        check("solve0_once", 32'(grant), 32'h0);

        // Paused arbitration keeps the request pending.
        enable = 1'b0; req = 4'b0100; event_code = 8'h00; acc = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            acc = acc | grant;
        end
        check("pause_nogrant", 32'(acc), 32'h0);
        check("pause_state",   32'(state), 32'(S_ARMED));
        enable = 1'b1; step();
        check("resume_grant", 32'(grant), 32'h4);
        req = 4'b0000;

        // Pointer now at 3: order 3,0,1,2 so module 1 wins first.
        req = 4'b0110; event_code = 8'b00_10_10_00;
        step();
        check("solve1_grant", 32'(grant), 32'h2);
        req = 4'b0100;
        step();
        check("solve2_grant", 32'(grant), 32'h4);
        check("solve2_solved", 32'(solved), 32'h7);
        req = 4'b0000;
        step();
        check("solve_state", 32'(state), 32'(S_ARMED));

        // Final solve arrives with the timeout: timeout wins.
        req = 4'b1000; event_code = 8'b10_00_00_00; timer_expired = 1'b1;
        step();
        check("timeout_state",  32'(state), 32'(S_LOST));
        check("timeout_grant",  32'(grant), 32'h0);
        check("timeout_solved", 32'(solved), 32'h7);
        check("timeout_lost",   32'(game_lost), 32'h1);
        check("timeout_won",    32'(game_won), 32'h0);

        // Restart from LOST.
        req = 4'b0000; timer_expired = 1'b0; begin_setup = 1'b1;
        step(); begin_setup = 1'b0;
        check("restart_strikes", 32'(strikes), 32'h0);
        check("restart_solved",  32'(solved), 32'h0);
        check("restart_state",   32'(state), 32'(S_SETUP));
        check("restart_lost",    32'(game_lost), 32'h0);
        step();
        check("rearm_state", 32'(state), 32'(S_ARMED));

        // Three strikes from module 2.
        event_code = 8'b00_01_00_00;
        for (int s = 1; s <= 3; s++) begin
            req = 4'b0100;
            step();
            check("strike_grant", 32'(grant), 32'h4);
            check("strike_count", 32'(strikes), 32'(s));
            check("strike_pulse", 32'(strike_pulse), 32'h1);
            req = 4'b0000;
            step();
            check("strike_pulse_off", 32'(strike_pulse), 32'h0);
            check("strike_state", 32'(state), (s == 3) ? 32'(S_LOST) : 32'(S_ARMED));
        end
        check("strike_lost", 32'(game_lost), 32'h1);
        req = 4'b0100;
        step();
        check("lost_nogrant", 32'(grant), 32'h0);
        check("lost_strikes", 32'(strikes), 32'h3);
        req = 4'b0000;

        // Win: all four modules solve.
        begin_setup = 1'b1; step(); begin_setup = 1'b0;
        step();
        req = 4'b1111; event_code = 8'b10_10_10_10;
        for (int k = 0; k < 4; k++) begin
            step();
            check("win_grant", 32'(grant), 32'(4'b0001 << k));
            req = req & ~grant;
        end
        check("win_solved", 32'(solved), 32'hf);
        step();
        check("win_state", 32'(state), 32'(S_WON));
        check("win_won",   32'(game_won), 32'h1);
        check("win_lost",  32'(game_lost), 32'h0);

        // Reset overrides everything, pending requests discarded.
        req = 4'b1111; event_code = 8'h00; reset = 1'b1; begin_setup = 1'b1;
        step();
        reset = 1'b0; begin_setup = 1'b0;
        check("rst2_state", 32'(state), 32'(S_IDLE));
        check("rst2_won",   32'(game_won), 32'h0);
        step();
        check("rst2_grant", 32'(grant), 32'h0);
        check("rst2_idle",  32'(state), 32'(S_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
